// File: rtl/imm_encoder_pkg.sv
// Shared immediate-source codes, FSM state encoding and the single-cycle
// range checks used by the immediate encoder.
package imm_encoder_pkg;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SEARCH = 1'b1;

  localparam logic [3:0] ROT_LAST = 4'd15;

  typedef struct packed {
    logic        valid;
    logic [23:0] field;
  } enc_t;

  // DP constant with rotation 0: only an unrotated byte fits.
  function automatic enc_t encode_dp0(input logic [31:0] value);
    enc_t r;
    r.valid = (value[31:8] == 24'd0);
    r.field = r.valid ? {16'd0, value[7:0]} : 24'd0;
    return r;
  endfunction

  function automatic enc_t encode_mem(input logic [31:0] value);
    enc_t r;
    r.valid = (value[31:12] == 20'd0);
    r.field = r.valid ? {12'd0, value[11:0]} : 24'd0;
    return r;
  endfunction

  // Word-aligned byte offset that sign-extends from bit 25.
  function automatic enc_t encode_br(input logic [31:0] value);
    enc_t r;
    r.valid = (value[1:0] == 2'b00) &&
              ((value[31:25] == 7'h00) || (value[31:25] == 7'h7f));
    r.field = r.valid ? value[25:2] : 24'd0;
    return r;
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Rotates a constant left by 2*rot and reports whether the result fits in
// the low byte, i.e. whether imm8 ROR (2*rot) can reproduce the constant.
module imm_rot_check (
  input  logic [31:0] value,
  input  logic [3:0]  rot,
  output logic [7:0]  t,
  output logic        fits
);

  logic [5:0]  shamt;
  logic [63:0] doubled;
  logic [31:0] rotated;

  assign shamt   = {1'b0, rot, 1'b0};
  // Bits shifted out of the upper copy are refilled from the lower copy.
  assign doubled = {value, value} << shamt;
  assign rotated = doubled[63:32];
  assign t       = rotated[7:0];
  assign fits    = (rotated[31:8] == 24'd0);

endmodule

// File: rtl/imm_encoder.sv
// Packs a 32-bit constant into the Instr[23:0] immediate field for a given
// ImmSrc; DP constants are found by a one-rotation-per-cycle search.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter bit ROT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  imm_src,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [23:0] instr_field
);

  logic [0:0]  state;
  logic [3:0]  rot;
  logic [31:0] value_q;
  logic [7:0]  rot_t;
  logic        rot_fits;
  enc_t        idle_res;
  logic        go_search;

  imm_rot_check u_rot_check (
    .value (value_q),
    .rot   (rot),
    .t     (rot_t),
    .fits  (rot_fits)
  );

  // Rotation 0 is tested directly on the incoming value at the accepting
  // edge, so the search proper starts at rotation 1 and latency is rot+1.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idle_res  = '0;
    go_search = 1'b0;
    case (imm_src)
      IMM_DP: begin
        idle_res  = encode_dp0(value);
        go_search = ROT_EN && !idle_res.valid;
      end
      IMM_MEM: idle_res = encode_mem(value);
      IMM_BR:  idle_res = encode_br(value);
      default: idle_res = '0;
    endcase
  end

  assign busy = (state == ST_SEARCH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rot         <= 4'd0;
      value_q     <= 32'd0;
      done        <= 1'b0;
      valid       <= 1'b0;
      instr_field <= 24'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            value_q <= value;
            if (go_search) begin
              state       <= ST_SEARCH;
              rot         <= 4'd1;
              valid       <= 1'b0;
              instr_field <= 24'd0;
            end else begin
              valid       <= idle_res.valid;
              instr_field <= idle_res.field;
              done        <= 1'b1;
            end
          end
        end
        ST_SEARCH: begin
          if (rot_fits) begin
            valid       <= 1'b1;
            instr_field <= {12'd0, rot, rot_t};
            done        <= 1'b1;
            state       <= ST_IDLE;
            rot         <= 4'd0;
          end else if (rot == ROT_LAST) begin
            valid       <= 1'b0;
            instr_field <= 24'd0;
            done        <= 1'b1;
            state       <= ST_IDLE;
            rot         <= 4'd0;
          end else begin
            rot <= rot + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          rot   <= 4'd0;
        end
      endcase
    end
  end

endmodule
